// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative shift-add multiply and the EX/MEM register.
// Multiply FSM: IDLE = single-cycle ops, MUL = one shift-add step per cycle, DONE = product handed to EX/MEM.
module ex_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        MEM_i,
  input  logic              ALU_Src_i,
  input  logic [1:0]        ALU_OP_i,
  input  logic              Reg_Dst_i,
  input  logic [DATA_W-1:0] Reg_data1_i,
  input  logic [DATA_W-1:0] Reg_data2_i,
  input  logic [DATA_W-1:0] immd_i,
  input  logic [ADDR_W-1:0] RsAddr_FW_i,
  input  logic [ADDR_W-1:0] RtAddr_FW_i,
  input  logic [ADDR_W-1:0] RtAddr_WB_i,
  input  logic [ADDR_W-1:0] RdAddr_WB_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [ADDR_W-1:0] MEMWB_Rd_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic              stall_o,
  output logic [1:0]        WB_o,
  output logic [1:0]        MEM_o,
  output logic [DATA_W-1:0] ALU_result_o,
  output logic [DATA_W-1:0] Wr_data_o,
  output logic [ADDR_W-1:0] RdAddr_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_ZERO} alu_sel_t;

  state_t state_q, state_d;
  alu_sel_t alu_sel;

  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lat_wb_q, lat_wb_d, lat_mem_q, lat_mem_d;
  logic [ADDR_W-1:0] lat_rd_q, lat_rd_d;
  logic [DATA_W-1:0] lat_st_q, lat_st_d;

  logic [1:0]        wb_q, wb_d, mem_q, mem_d;
  logic [DATA_W-1:0] res_q, res_d, wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic [ADDR_W-1:0] dst;
  logic              stall;

  assign WB_o         = wb_q;
  assign MEM_o        = mem_q;
  assign ALU_result_o = res_q;
  assign Wr_data_o    = wr_q;
  assign RdAddr_o     = rd_q;
  assign stall_o      = stall;

  // EX/MEM hit beats MEM/WB hit; r0 never forwards
  always_comb begin
    fwd_a = Reg_data1_i;
    if (wb_q[1] && rd_q != '0 && rd_q == RsAddr_FW_i)
      fwd_a = res_q;
    else if (MEMWB_RegWrite_i && MEMWB_Rd_i != '0 && MEMWB_Rd_i == RsAddr_FW_i)
      fwd_a = MEMWB_data_i;

    fwd_b = Reg_data2_i;
    if (wb_q[1] && rd_q != '0 && rd_q == RtAddr_FW_i)
      fwd_b = res_q;
    else if (MEMWB_RegWrite_i && MEMWB_Rd_i != '0 && MEMWB_Rd_i == RtAddr_FW_i)
      fwd_b = MEMWB_data_i;
  end

  assign op_b = ALU_Src_i ? immd_i : fwd_b;
  assign dst  = Reg_Dst_i ? RdAddr_WB_i : RtAddr_WB_i;

  always_comb begin
    alu_sel = OP_ZERO;
    case (ALU_OP_i)
      2'b00: alu_sel = OP_ADD;
      2'b01: alu_sel = OP_SUB;
      2'b11: alu_sel = OP_OR;
      default: begin
        case (immd_i[5:0])
          6'b100000: alu_sel = OP_ADD;
          6'b100010: alu_sel = OP_SUB;
          6'b100100: alu_sel = OP_AND;
          6'b100101: alu_sel = OP_OR;
          6'b101010: alu_sel = OP_SLT;
          6'b011000: alu_sel = OP_MUL;
          default:   alu_sel = OP_ZERO;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      OP_ADD:  alu_res = fwd_a + op_b;
      OP_SUB:  alu_res = fwd_a - op_b;
      OP_AND:  alu_res = fwd_a & op_b;
      OP_OR:   alu_res = fwd_a | op_b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // Low DATA_W bits of an unsigned shift-add equal the signed product's low bits.
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    lat_wb_d  = lat_wb_q;
    lat_mem_d = lat_mem_q;
    lat_rd_d  = lat_rd_q;
    lat_st_d  = lat_st_q;
    stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (alu_sel == OP_MUL) begin
          stall     = 1'b1;
          mul_a_d   = fwd_a;
          mul_b_d   = op_b;
          acc_d     = '0;
          cnt_d     = '0;
          lat_wb_d  = WB_i;
          lat_mem_d = MEM_i;
          lat_rd_d  = dst;
          lat_st_d  = fwd_b;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        stall   = 1'b1;
        acc_d   = mul_b_q[0] ? acc_q + mul_a_q : acc_q;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_d  = WB_i;
    mem_d = MEM_i;
    res_d = alu_res;
    wr_d  = fwd_b;
    rd_d  = dst;
    if (stall) begin
      wb_d  = '0;
      mem_d = '0;
      res_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else if (state_q == S_DONE) begin
      wb_d  = lat_wb_q;
      mem_d = lat_mem_q;
      res_d = acc_q;
      wr_d  = lat_st_q;
      rd_d  = lat_rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      lat_wb_q  <= '0;
      lat_mem_q <= '0;
      lat_rd_q  <= '0;
      lat_st_q  <= '0;
      wb_q      <= '0;
      mem_q     <= '0;
      res_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      lat_wb_q  <= lat_wb_d;
      lat_mem_q <= lat_mem_d;
      lat_rd_q  <= lat_rd_d;
      lat_st_q  <= lat_st_d;
      wb_q      <= wb_d;
      mem_q     <= mem_d;
      res_q     <= res_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand sequences for multiply and reset.
module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  WB_i, MEM_i, ALU_OP_i;
  logic        ALU_Src_i, Reg_Dst_i, MEMWB_RegWrite_i;
  logic [31:0] Reg_data1_i, Reg_data2_i, immd_i, MEMWB_data_i;
  logic [5:0]  RsAddr_FW_i, RtAddr_FW_i, RtAddr_WB_i, RdAddr_WB_i, MEMWB_Rd_i;
  logic        stall_o;
  logic [1:0]  WB_o, MEM_o;
  logic [31:0] ALU_result_o, Wr_data_o;
  logic [5:0]  RdAddr_o;

  int errors = 0;
  int checks = 0;

  ex_stage #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .MEM_i(MEM_i), .ALU_Src_i(ALU_Src_i),
    .ALU_OP_i(ALU_OP_i), .Reg_Dst_i(Reg_Dst_i), .Reg_data1_i(Reg_data1_i),
    .Reg_data2_i(Reg_data2_i), .immd_i(immd_i), .RsAddr_FW_i(RsAddr_FW_i),
    .RtAddr_FW_i(RtAddr_FW_i), .RtAddr_WB_i(RtAddr_WB_i), .RdAddr_WB_i(RdAddr_WB_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_Rd_i(MEMWB_Rd_i), .MEMWB_data_i(MEMWB_data_i),
    .stall_o(stall_o), .WB_o(WB_o), .MEM_o(MEM_o), .ALU_result_o(ALU_result_o),
    .Wr_data_o(Wr_data_o), .RdAddr_o(RdAddr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  wb, mem;
    logic        src;
    logic [1:0]  op;
    logic        dst;
    logic [31:0] d1, d2, imm;
    logic [5:0]  rs, rt, rtwb, rd;
    logic        mwe;
    logic [5:0]  mrd;
    logic [31:0] mdata;
    logic [1:0]  e_wb, e_mem;
    logic [31:0] e_res, e_wr;
    logic [5:0]  e_rd;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_nop();
    WB_i = 2'b00; MEM_i = 2'b00; ALU_Src_i = 1'b0; ALU_OP_i = 2'b00; Reg_Dst_i = 1'b0;
    Reg_data1_i = '0; Reg_data2_i = '0; immd_i = '0;
    RsAddr_FW_i = '0; RtAddr_FW_i = '0; RtAddr_WB_i = '0; RdAddr_WB_i = '0;
    MEMWB_RegWrite_i = 1'b0; MEMWB_Rd_i = '0; MEMWB_data_i = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string nm;
    WB_i = v.wb; MEM_i = v.mem; ALU_Src_i = v.src; ALU_OP_i = v.op; Reg_Dst_i = v.dst;
    Reg_data1_i = v.d1; Reg_data2_i = v.d2; immd_i = v.imm;
    RsAddr_FW_i = v.rs; RtAddr_FW_i = v.rt; RtAddr_WB_i = v.rtwb; RdAddr_WB_i = v.rd;
    MEMWB_RegWrite_i = v.mwe; MEMWB_Rd_i = v.mrd; MEMWB_data_i = v.mdata;
    #1;
    nm = $sformatf("v%0d", idx);
    chk({nm, " stall"}, {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    chk({nm, " wb"}, {30'b0, WB_o}, {30'b0, v.e_wb});
    chk({nm, " mem"}, {30'b0, MEM_o}, {30'b0, v.e_mem});
    chk({nm, " result"}, ALU_result_o, v.e_res);
    chk({nm, " wrdata"}, Wr_data_o, v.e_wr);
    chk({nm, " rd"}, {26'b0, RdAddr_o}, {26'b0, v.e_rd});
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [5:0] rd,
                        input logic [31:0] exp, input string nm);
    int n;
    bit bub_ok;
    drive_nop();
    WB_i = 2'b10; ALU_OP_i = 2'b10; Reg_Dst_i = 1'b1; immd_i = 32'h18;
    Reg_data1_i = a; Reg_data2_i = b; RdAddr_WB_i = rd;
    #1;
    n = 0;
    bub_ok = 1'b1;
    while (stall_o && n < 40) begin
      if (n > 0 && (WB_o != 2'b00 || MEM_o != 2'b00 || ALU_result_o != '0 || RdAddr_o != '0))
        bub_ok = 1'b0;
      if (n == 5) begin
        // operands must already be latched; disturb every source
        Reg_data1_i = 32'h0; Reg_data2_i = 32'h0;
        MEMWB_RegWrite_i = 1'b1; MEMWB_Rd_i = 6'd1; MEMWB_data_i = 32'hDEAD;
      end
      @(posedge clk_i); #1;
      n++;
    end
    chk({nm, " stall cycles"}, n, 33);
    chk({nm, " bubbles"}, {31'b0, bub_ok}, 32'd1);
    @(posedge clk_i); #1;
    chk({nm, " product"}, ALU_result_o, exp);
    chk({nm, " wb"}, {30'b0, WB_o}, 32'd2);
    chk({nm, " rd"}, {26'b0, RdAddr_o}, {26'b0, rd});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit clean;
    //          wb mem src op dst d1           d2           imm   rs rt rtwb rd mwe mrd mdata  e_wb e_mem e_res        e_wr         e_rd
    vecs[0]  = '{2, 0, 1, 0, 1, 'h10,        0,           0,    0, 0, 0,  3,  0, 0, 0,     2, 0, 'h10,        0,           3};
    vecs[1]  = '{2, 0, 0, 2, 1, 'hAAAA,      5,           'h20, 3, 4, 0,  5,  1, 3, 'h20,  2, 0, 'h15,        5,           5};
    vecs[2]  = '{2, 0, 1, 0, 1, 'h99,        0,           0,    0, 0, 0,  0,  0, 0, 0,     2, 0, 'h99,        0,           0};
    vecs[3]  = '{2, 0, 0, 2, 1, 'hAAAA,      5,           'h20, 3, 4, 0,  6,  1, 3, 'h20,  2, 0, 'h25,        5,           6};
    vecs[4]  = '{2, 1, 0, 0, 0, 1,           'h777,       0,    0, 6, 7,  0,  0, 0, 0,     2, 1, 'h26,        'h25,        7};
    vecs[5]  = '{1, 0, 1, 0, 1, 'h40,        0,           0,    0, 0, 0,  8,  0, 0, 0,     1, 0, 'h40,        0,           8};
    vecs[6]  = '{0, 0, 1, 0, 1, 3,           0,           0,    8, 0, 0,  0,  0, 0, 0,     0, 0, 3,           0,           0};
    vecs[7]  = '{2, 0, 0, 1, 1, 'hFFFFFFFE,  1,           0,    0, 0, 0,  9,  0, 0, 0,     2, 0, 'hFFFFFFFD,  1,           9};
    vecs[8]  = '{2, 0, 0, 2, 1, 'hFFFFFFFE,  1,           'h2A, 0, 0, 0,  9,  0, 0, 0,     2, 0, 1,           1,           9};
    vecs[9]  = '{2, 0, 0, 2, 1, 'hFFFFFFFE,  1,           'h24, 0, 0, 0,  9,  0, 0, 0,     2, 0, 0,           1,           9};
    vecs[10] = '{2, 0, 0, 2, 1, 'hFFFFFFFE,  1,           'h25, 0, 0, 0,  9,  0, 0, 0,     2, 0, 'hFFFFFFFF,  1,           9};
    vecs[11] = '{2, 0, 0, 3, 1, 'hF0,        'h0F,        0,    0, 0, 0,  9,  0, 0, 0,     2, 0, 'hFF,        'h0F,        9};
    vecs[12] = '{2, 0, 0, 2, 1, 5,           7,           'h22, 0, 0, 0,  9,  0, 0, 0,     2, 0, 'hFFFFFFFE,  7,           9};
    vecs[13] = '{2, 0, 0, 2, 1, 5,           7,           'h3F, 0, 0, 0,  9,  0, 0, 0,     2, 0, 0,           7,           9};
    vecs[14] = '{3, 2, 1, 0, 0, 'hFFFFFFFE,  'h1234,      8,    0, 0, 10, 0,  0, 0, 0,     3, 2, 6,           'h1234,      10};
    vecs[15] = '{0, 1, 1, 0, 0, 'h100,       'hBEEF,      8,    0, 10, 10, 0, 0, 0, 0,     0, 1, 'h108,       6,           10};
    vecs[16] = '{2, 0, 0, 2, 1, 1,           'hFFFFFFFE,  'h2A, 0, 0, 0,  11, 0, 0, 0,     2, 0, 0,           'hFFFFFFFE,  11};
    vecs[17] = '{0, 0, 0, 0, 1, 1,           'h999,       0,    0, 20, 0, 0,  1, 20, 'h55, 0, 0, 'h56,        'h55,        0};
    vecs[18] = '{0, 0, 1, 0, 1, 7,           0,           0,    0, 0, 0,  0,  1, 0, 'h123, 0, 0, 7,           0,           0};
    vecs[19] = '{2, 0, 0, 0, 1, 4,           9,           0,    0, 0, 0,  14, 0, 0, 0,     2, 0, 'hD,         9,           14};

    // reset with random inputs
    rst_i = 1'b1;
    WB_i = 2'($urandom); MEM_i = 2'($urandom); ALU_Src_i = 1'($urandom); ALU_OP_i = 2'($urandom);
    Reg_Dst_i = 1'($urandom); Reg_data1_i = $urandom; Reg_data2_i = $urandom; immd_i = $urandom;
    RsAddr_FW_i = 6'($urandom); RtAddr_FW_i = 6'($urandom); RtAddr_WB_i = 6'($urandom);
    RdAddr_WB_i = 6'($urandom); MEMWB_RegWrite_i = 1'($urandom); MEMWB_Rd_i = 6'($urandom);
    MEMWB_data_i = $urandom;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst wb", {30'b0, WB_o}, 32'd0);
    chk("rst mem", {30'b0, MEM_o}, 32'd0);
    chk("rst result", ALU_result_o, 32'd0);
    chk("rst wrdata", Wr_data_o, 32'd0);
    chk("rst rd", {26'b0, RdAddr_o}, 32'd0);
    drive_nop();
    rst_i = 1'b0;
    #1;
    chk("rst stall", {31'b0, stall_o}, 32'd0);

    for (int i = 0; i < 19; i++) apply(vecs[i], i);

    do_mul(32'hFFFFFFF9, 32'd6, 6'd12, 32'hFFFFFFD6, "mul_neg");

    do_mul(32'h7FFFFFFF, 32'd2, 6'd13, 32'hFFFFFFFE, "mul_b2b1");
    do_mul(32'd3, 32'd5, 6'd15, 32'd15, "mul_b2b2");
    apply(vecs[19], 19);

    // reset during MUL at count 15
    drive_nop();
    WB_i = 2'b10; ALU_OP_i = 2'b10; Reg_Dst_i = 1'b1; immd_i = 32'h18;
    Reg_data1_i = 32'd3; Reg_data2_i = 32'd5; RdAddr_WB_i = 6'd16;
    #1;
    repeat (16) begin @(posedge clk_i); #1; end
    chk("midrst stall before", {31'b0, stall_o}, 32'd1);
    rst_i = 1'b1;
    drive_nop();
    @(posedge clk_i); #1;
    chk("midrst wb", {30'b0, WB_o}, 32'd0);
    chk("midrst result", ALU_result_o, 32'd0);
    chk("midrst rd", {26'b0, RdAddr_o}, 32'd0);
    chk("midrst stall", {31'b0, stall_o}, 32'd0);
    rst_i = 1'b0;
    clean = 1'b1;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (stall_o || ALU_result_o != '0 || WB_o != 2'b00 || RdAddr_o != '0) clean = 1'b0;
    end
    chk("midrst no product", {31'b0, clean}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
